// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: PC counter, one-deep in-flight tracking
// against a 1-cycle synchronous imem, and a DEPTH-entry {pc, instr} queue to decode.
module fetch_queue #(
    parameter int PC_W     = 9,
    parameter int INS_W    = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_en,
    output logic [PC_W-1:0]              imem_addr,
    input  logic [INS_W-1:0]             imem_rdata,
    output logic                         id_valid,
    output logic [PC_W-1:0]              id_pc,
    output logic [INS_W-1:0]             id_instr,
    input  logic                         id_stall,
    input  logic                         redirect,
    input  logic [PC_W-1:0]              redirect_pc,
    input  logic                         halt,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic [PC_W-1:0]              fetch_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PC_W-1:0]  PC_RST   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);
    localparam logic [PC_W-1:0]  PC_MASK  = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   CREDIT_LIM = (CNT_W+1)'(DEPTH);

    logic [PC_W-1:0]  fetch_pc_r;
    logic             inflight_v_r;
    logic [PC_W-1:0]  inflight_pc_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PC_W-1:0]  pc_q_r  [DEPTH];
    logic [INS_W-1:0] ins_q_r [DEPTH];

    logic             valid_s;
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [CNT_W:0]   credit_s;

    // Handshake and credit decode; credit counts queued + in-flight slots after this cycle's pop.
    always_comb begin
        valid_s  = (count_r != {CNT_W{1'b0}});
        pop_s    = valid_s && !id_stall && !redirect && !reset;
        push_s   = inflight_v_r && !redirect && !reset;
        credit_s = {1'b0, count_r}
                 + {{CNT_W{1'b0}}, inflight_v_r}
                 - {{CNT_W{1'b0}}, pop_s};
        issue_s  = !reset && !redirect && !halt && (credit_s < CREDIT_LIM);
    end

    // Fetch PC, in-flight tracking and queue pointers; redirect flushes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= PC_RST;
            inflight_v_r  <= 1'b0;
            inflight_pc_r <= {PC_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else if (redirect) begin
            fetch_pc_r    <= redirect_pc & PC_MASK;
            inflight_v_r  <= 1'b0;
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else begin
            if (issue_s) begin
                inflight_v_r  <= 1'b1;
                inflight_pc_r <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + PC_STEP;
            end else begin
                inflight_v_r  <= 1'b0;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only observable through valid entries, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_q_r[wr_ptr_r]  <= inflight_pc_r;
            ins_q_r[wr_ptr_r] <= imem_rdata;
        end
    end

    assign imem_en   = issue_s;
    assign imem_addr = fetch_pc_r;
    assign id_valid  = valid_s;
    assign id_pc     = valid_s ? pc_q_r[rd_ptr_r]  : {PC_W{1'b0}};
    assign id_instr  = valid_s ? ins_q_r[rd_ptr_r] : {INS_W{1'b0}};
    assign q_count   = count_r;
    assign fetch_pc  = fetch_pc_r;

    fetch_queue_chk #(.CNT_W(CNT_W), .DEPTH(DEPTH)) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r),
        .full  (count_r == CNT_FULL)
    );

endmodule

// Protocol checks for fetch_queue: a response must never land in a full queue.
module fetch_queue_chk #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count,
    input logic             full
);

    // Credit-based issue must keep occupancy within DEPTH.
    assert property (@(posedge clk) disable iff (reset) !(push && !pop && full));
    assert property (@(posedge clk) disable iff (reset) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven cycle vectors plus
// directed sequences for full-queue redirect, halt drain, mid-run reset and PC wrap.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset, id_stall, redirect, halt;
    logic [8:0]  redirect_pc;
    logic        imem_en, id_valid;
    logic [8:0]  imem_addr, id_pc, fetch_pc;
    logic [31:0] imem_rdata, id_instr;
    logic [2:0]  q_count;

    logic        reset2, stall2, redirect2, halt2;
    logic [8:0]  redirect_pc2;
    logic        imem_en2, id_valid2;
    logic [8:0]  imem_addr2, id_pc2, fetch_pc2;
    logic [31:0] imem_rdata2, id_instr2;
    logic [2:0]  q_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_stall(id_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .q_count(q_count),
        .fetch_pc(fetch_pc)
    );

    fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(9'h1F8)) dut2 (
        .clk(clk), .reset(reset2), .imem_en(imem_en2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .id_valid(id_valid2), .id_pc(id_pc2),
        .id_instr(id_instr2), .id_stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .halt(halt2), .q_count(q_count2),
        .fetch_pc(fetch_pc2)
    );

    function automatic logic [31:0] tag(input logic [8:0] pc);
        return {16'hC0DE, 7'h00, pc};
    endfunction

    // Synchronous instruction memories returning PC-tagged words one cycle after request.
    always @(posedge clk) begin
        imem_rdata  <= imem_en  ? tag(imem_addr)  : 32'hBAD0_0000;
        imem_rdata2 <= imem_en2 ? tag(imem_addr2) : 32'hBAD0_0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rdr,
                         input logic [8:0] rpc, input logic hlt);
        @(negedge clk);
        reset = rst; id_stall = stl; redirect = rdr; redirect_pc = rpc; halt = hlt;
        #1;
    endtask

    task automatic chk_head(input string name, input logic v, input logic [8:0] pc);
        chk({name, ".valid"}, {31'h0, id_valid}, {31'h0, v});
        chk({name, ".pc"}, {23'h0, id_pc}, {23'h0, pc});
        chk({name, ".instr"}, id_instr, v ? tag(pc) : 32'h0);
    endtask

    typedef struct {
        logic       rst, stall, redir;
        logic [8:0] rpc;
        logic       halt;
        logic       en, valid;
        logic [8:0] pc;
        logic [2:0] cnt;
        logic [8:0] fpc;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] hexp [3];
        logic [8:0] wexp [6];
        int pops;
        logic seen_bad;

        //            rst stl rdr rpc     hlt  en val pc      cnt   fpc
        tbl[0]  = '{1'b1,1'b0,1'b0,9'h000,1'b0,1'b0,1'b0,9'h000,3'd0,9'h000};
        tbl[1]  = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b0,9'h000,3'd0,9'h000};
        tbl[2]  = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b0,9'h000,3'd0,9'h004};
        tbl[3]  = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h000,3'd1,9'h008};
        tbl[4]  = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h004,3'd1,9'h00C};
        tbl[5]  = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h008,3'd1,9'h010};
        tbl[6]  = '{1'b0,1'b1,1'b0,9'h000,1'b0,1'b1,1'b1,9'h00C,3'd1,9'h014};
        tbl[7]  = '{1'b0,1'b1,1'b0,9'h000,1'b0,1'b1,1'b1,9'h00C,3'd2,9'h018};
        tbl[8]  = '{1'b0,1'b1,1'b0,9'h000,1'b0,1'b0,1'b1,9'h00C,3'd3,9'h01C};
        tbl[9]  = '{1'b0,1'b1,1'b0,9'h000,1'b0,1'b0,1'b1,9'h00C,3'd4,9'h01C};
        tbl[10] = '{1'b0,1'b1,1'b0,9'h000,1'b0,1'b0,1'b1,9'h00C,3'd4,9'h01C};
        tbl[11] = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h00C,3'd4,9'h01C};
        tbl[12] = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h010,3'd3,9'h020};
        tbl[13] = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h014,3'd3,9'h024};
        tbl[14] = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h018,3'd3,9'h028};
        tbl[15] = '{1'b0,1'b0,1'b1,9'h043,1'b0,1'b0,1'b1,9'h01C,3'd3,9'h02C};
        tbl[16] = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b0,9'h000,3'd0,9'h040};
        tbl[17] = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b0,9'h000,3'd0,9'h044};
        tbl[18] = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h040,3'd1,9'h048};
        tbl[19] = '{1'b0,1'b0,1'b0,9'h000,1'b0,1'b1,1'b1,9'h044,3'd1,9'h04C};

        reset = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 9'h0; halt = 1'b0;
        reset2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 9'h0; halt2 = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 9'h000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].halt);
            chk($sformatf("v%0d.en", i), {31'h0, imem_en}, {31'h0, tbl[i].en});
            chk($sformatf("v%0d.count", i), {29'h0, q_count}, {29'h0, tbl[i].cnt});
            chk($sformatf("v%0d.fetch_pc", i), {23'h0, fetch_pc}, {23'h0, tbl[i].fpc});
            chk($sformatf("v%0d.addr", i), {23'h0, imem_addr}, {23'h0, tbl[i].fpc});
            chk_head($sformatf("v%0d", i), tbl[i].valid, tbl[i].pc);
        end

        // Fill the queue under stall, then redirect while still stalled.
        drive(1'b0, 1'b1, 1'b0, 9'h000, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 9'h000, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 9'h000, 1'b0);
        chk("fill3.en", {31'h0, imem_en}, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 9'h000, 1'b0);
        chk("full.count", {29'h0, q_count}, 32'h4);
        chk("full.en", {31'h0, imem_en}, 32'h0);
        chk_head("full", 1'b1, 9'h048);
        drive(1'b0, 1'b1, 1'b1, 9'h0A7, 1'b0);
        chk("rd.en", {31'h0, imem_en}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk("rd1.count", {29'h0, q_count}, 32'h0);
        chk("rd1.fetch_pc", {23'h0, fetch_pc}, 32'h0A4);
        chk("rd1.en", {31'h0, imem_en}, 32'h1);
        chk_head("rd1", 1'b0, 9'h000);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk_head("rd2", 1'b0, 9'h000);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk_head("rd3", 1'b1, 9'h0A4);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk_head("rd4", 1'b1, 9'h0A8);

        // Two queued plus one in flight, then halt: exactly three more pops.
        drive(1'b0, 1'b1, 1'b0, 9'h000, 1'b0);
        chk("pre_halt.count", {29'h0, q_count}, 32'h1);
        hexp[0] = 9'h0AC; hexp[1] = 9'h0B0; hexp[2] = 9'h0B4;
        pops = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b1);
            chk($sformatf("halt%0d.en", k), {31'h0, imem_en}, 32'h0);
            chk($sformatf("halt%0d.fetch_pc", k), {23'h0, fetch_pc}, 32'h0B8);
            if (id_valid) begin
                if (pops < 3) chk($sformatf("halt%0d.pc", k), {23'h0, id_pc}, {23'h0, hexp[pops]});
                pops++;
            end
        end
        chk("halt.pops", pops, 32'd3);
        chk("halt.drained", {31'h0, id_valid}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk("resume.en", {31'h0, imem_en}, 32'h1);
        chk("resume.addr", {23'h0, imem_addr}, 32'h0B8);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk_head("resume2", 1'b0, 9'h000);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk_head("resume3", 1'b1, 9'h0B8);

        // Redirect during halt updates fetch_pc but issues nothing until halt falls.
        drive(1'b0, 1'b0, 1'b1, 9'h101, 1'b1);
        chk("rh.en", {31'h0, imem_en}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b1);
        chk("rh1.en", {31'h0, imem_en}, 32'h0);
        chk("rh1.fetch_pc", {23'h0, fetch_pc}, 32'h100);
        chk("rh1.count", {29'h0, q_count}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk("rh2.en", {31'h0, imem_en}, 32'h1);
        chk("rh2.addr", {23'h0, imem_addr}, 32'h100);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk_head("rh3", 1'b0, 9'h000);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk_head("rh4", 1'b1, 9'h100);

        // Three queued and one in flight, then a reset pulse.
        drive(1'b0, 1'b1, 1'b0, 9'h000, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 9'h000, 1'b0);
        chk("prerst.count", {29'h0, q_count}, 32'h2);
        drive(1'b1, 1'b0, 1'b0, 9'h000, 1'b0);
        chk("rst.count_pre", {29'h0, q_count}, 32'h3);
        chk("rst.en", {31'h0, imem_en}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk("rst1.count", {29'h0, q_count}, 32'h0);
        chk("rst1.fetch_pc", {23'h0, fetch_pc}, 32'h000);
        chk("rst1.en", {31'h0, imem_en}, 32'h1);
        chk_head("rst1", 1'b0, 9'h000);
        seen_bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
            if (id_instr == tag(9'h110)) seen_bad = 1'b1;
            if (k == 0) chk_head("rst_k0", 1'b0, 9'h000);
            else chk_head($sformatf("rst_k%0d", k), 1'b1, 9'((k - 1) * 4));
        end
        chk("rst.squashed_absent", {31'h0, seen_bad}, 32'h0);

        // Second instance: RESET_PC near the top of the 9-bit space wraps to zero.
        wexp[0] = 9'h000; wexp[1] = 9'h000; wexp[2] = 9'h1F8;
        wexp[3] = 9'h1FC; wexp[4] = 9'h000; wexp[5] = 9'h004;
        @(negedge clk);
        reset2 = 1'b0;
        #1;
        chk("wrap.en", {31'h0, imem_en2}, 32'h1);
        chk("wrap.addr", {23'h0, imem_addr2}, 32'h1F8);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("wrap%0d.valid", k), {31'h0, id_valid2}, {31'h0, (k >= 2) ? 1'b1 : 1'b0});
            chk($sformatf("wrap%0d.pc", k), {23'h0, id_pc2}, {23'h0, wexp[k]});
            chk($sformatf("wrap%0d.instr", k), id_instr2, (k >= 2) ? tag(wexp[k]) : 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single-register PC/IF_ID path with a decoupled prefetch queue.
- Holds a PC counter and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/stall handshake.
- Supports branch redirect with flush of queued and in-flight fetches, and a halt mode that stops fetching while letting the queue drain.

Parameters:
- PC_W, 9, PC / instruction-memory byte-address width.
- INS_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, fetch PC after reset; must be a multiple of 4.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_en  out  1  fetch request this cycle.
- imem_addr  out  PC_W  fetch address; equals fetch_pc.
- imem_rdata  in  INS_W  instruction, valid the cycle after imem_en.
- id_valid  out  1  queue head is valid.
- id_pc  out  PC_W  head PC; 0 when !id_valid.
- id_instr  out  INS_W  head instruction; 0 when !id_valid.
- id_stall  in  1  decode cannot accept (hazard stall); pop = id_valid && !id_stall.
- redirect  in  1  branch/jump taken: flush and refetch.
- redirect_pc  in  PC_W  redirect target; bits [1:0] ignored (treated as 0).
- halt  in  1  stop issuing new fetches while high.
- q_count  out  $clog2(DEPTH+1)  occupied entries (debug).
- fetch_pc  out  PC_W  next PC to be fetched (debug).

Behaviour:
- Reset: fetch_pc=RESET_PC; queue empty; q_count=0; in-flight flag clear; id_valid=0; id_pc=0; id_instr=0. imem_en=0 in every cycle reset is high.
- A reset asserted mid-operation discards all queued and in-flight instructions.
- State: fetch_pc; inflight_v; inflight_pc; FIFO (rd_ptr, wr_ptr, count).
- Issue: imem_en = !reset && !redirect && !halt && (count + inflight_v - pop) < DEPTH.
  - On issue: inflight_v<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - The addition is modulo 2^PC_W, so wrap-around is silent.
- Response: when inflight_v=1 and there is no redirect, imem_rdata and inflight_pc are written at wr_ptr at the clock edge.
  - The credit rule guarantees no overflow; writing to a full queue is a design error, flagged by an assertion.
- Dequeue: on pop, rd_ptr advances.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Head outputs are driven from the FIFO entry at rd_ptr. There is no bypass from imem_rdata to id_*: minimum latency from issue to id_valid is 2 cycles.
- Redirect (highest priority below reset):
  - Same edge: count<=0, pointers<=0, inflight_v<=0 (the in-flight response is squashed), fetch_pc<={redirect_pc[PC_W-1:2],2'b00}.
  - No issue during the redirect cycle; no pop is counted.
  - Target issued at T+1, enqueued at the T+2 edge, id_valid=1 with id_pc=target at T+3.
- Redirect together with id_stall: the flush still occurs.
- Redirect together with halt: fetch_pc is updated, but no issue occurs until halt falls.
- Halt: no new issue. The outstanding in-flight response is still enqueued, the queue drains normally, and fetch_pc holds.
- Halt deasserted: issue resumes next cycle from the held fetch_pc.
- Stall held indefinitely: the queue fills to DEPTH, imem_en falls, and no instruction is lost or duplicated.
- Output order always equals fetch order: PCs strictly sequential (+4 mod 2^PC_W) between redirects.

Test Plan:
- Reset release at cycle 0, id_stall=0, imem returning PC-tagged words -> imem_en=1 from cycle 0; id_valid=1 from cycle 2; id_pc sequence 0x000,0x004,0x008,... one per cycle with no gaps.
- id_stall=1 for 10 cycles after the first fetch -> q_count saturates at 4, imem_en=0 while full, id_pc frozen at 0x000; on release, id_pc 0x000..0x01C appears contiguous with no duplicates.
- Full queue, then redirect=1 with redirect_pc=0x043 -> next cycle q_count=0 and id_valid=0; in-flight word not delivered; id_pc=0x040 three cycles after redirect, then 0x044.
- halt=1 with 2 entries queued and 1 in flight -> exactly 3 further pops, then id_valid=0; fetch_pc holds; halt=0 resumes at the held PC.
- RESET_PC=0x1F8, PC_W=9 -> id_pc sequence 0x1F8, 0x1FC, 0x000, 0x004.
- Reset pulsed while queue holds 3 entries and a fetch is in flight -> next cycle id_valid=0, q_count=0, fetch_pc=RESET_PC; the squashed in-flight word never appears on id_instr.
